// File: rtl/mips_cpu_lsu_pkg.sv
// ---------------------------------------------------------------------------
// mips_cpu_lsu_pkg
//   Shared types and helpers for the MIPS load/store unit.
//   - lsu_op_t    : 4-bit load/store operation encodings
//   - lsu_state_t : LSU sequencing states
//   - lane/shift constants used by the alignment datapath
//   - is_load / is_store / is_busy_state / misaligned helper functions
// ---------------------------------------------------------------------------
package mips_cpu_lsu_pkg;

    typedef enum logic [3:0] {
        OP_LB  = 4'h0,
        OP_LBU = 4'h1,
        OP_LH  = 4'h2,
        OP_LHU = 4'h3,
        OP_LW  = 4'h4,
        OP_LWL = 4'h5,
        OP_LWR = 4'h6,
        OP_SB  = 4'h8,
        OP_SH  = 4'h9,
        OP_SW  = 4'hA
    } lsu_op_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_WR     = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4,
        ST_DONE   = 3'd5
    } lsu_state_t;

    localparam int WORD_W = 32;
    localparam int HALF_W = 16;
    localparam int BYTE_W = 8;

    function automatic logic is_load(input lsu_op_t op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR};
    endfunction

    function automatic logic is_store(input lsu_op_t op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    // States in which the LSU owns the memory port and cannot take a request.
    function automatic logic is_busy_state(input lsu_state_t st);
        return st inside {ST_RD, ST_WR, ST_RMW_RD, ST_RMW_WR};
    endfunction

    // Halfword ops need a[0]==0, word ops need a[1:0]==0. LWL/LWR and byte
    // ops accept any alignment.
    function automatic logic misaligned(input lsu_op_t op, input logic [1:0] a);
        case (op)
            OP_LH, OP_LHU, OP_SH: return a[0];
            OP_LW, OP_SW:         return (a != 2'b00);
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_cpu_lsu_align.sv
// ---------------------------------------------------------------------------
// mips_cpu_lsu_align
//   Combinational data alignment for the LSU.
//   Ports:
//     op         in  : operation being executed
//     byte_off   in  : request address bits [1:0]
//     mem_word   in  : word returned by data memory (little-endian lanes)
//     rt_old     in  : previous rt value, merged by LWL/LWR
//     wdata      in  : store data (rt)
//     load_data  out : extended / merged load result
//     store_word out : word to write back (sub-word lanes replaced)
// ---------------------------------------------------------------------------
module mips_cpu_lsu_align
    import mips_cpu_lsu_pkg::*;
(
    input  lsu_op_t     op,
    input  logic [1:0]  byte_off,
    input  logic [31:0] mem_word,
    input  logic [31:0] rt_old,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [4:0]  byte_shift;
    logic [4:0]  half_shift;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_shift = {byte_off, 3'b000};
        half_shift = {byte_off[1], 4'b0000};
        byte_sel   = mem_word[byte_shift +: BYTE_W];
        half_sel   = mem_word[half_shift +: HALF_W];

        load_data = '0;
        case (op)
            OP_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU: load_data = {24'h000000, byte_sel};
            OP_LH:  load_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU: load_data = {16'h0000, half_sel};
            OP_LW:  load_data = mem_word;
            // LWL: memory bytes 0..k land in the top of rt, low bytes of rt kept.
            OP_LWL: begin
                case (byte_off)
                    2'd0:    load_data = {mem_word[7:0],  rt_old[23:0]};
                    2'd1:    load_data = {mem_word[15:0], rt_old[15:0]};
                    2'd2:    load_data = {mem_word[23:0], rt_old[7:0]};
                    default: load_data = mem_word;
                endcase
            end
            // LWR: memory bytes k..3 land in the bottom of rt, high bytes kept.
            OP_LWR: begin
                case (byte_off)
                    2'd0:    load_data = mem_word;
                    2'd1:    load_data = {rt_old[31:24], mem_word[31:8]};
                    2'd2:    load_data = {rt_old[31:16], mem_word[31:16]};
                    default: load_data = {rt_old[31:8],  mem_word[31:24]};
                endcase
            end
            default: load_data = '0;
        endcase

        store_word = mem_word;
        case (op)
            OP_SB:   store_word[byte_shift +: BYTE_W] = wdata[7:0];
            OP_SH:   store_word[half_shift +: HALF_W] = wdata[15:0];
            OP_SW:   store_word = wdata;
            default: store_word = mem_word;
        endcase
    end

endmodule

// File: rtl/mips_cpu_lsu.sv
// ---------------------------------------------------------------------------
// mips_cpu_lsu
//   Load/store unit between the execute stage and a word-wide data memory
//   without byte enables. Sub-word stores are done as read-modify-write.
//   Ports:
//     clk, reset (sync, active-low), clk_enable (0 freezes all state)
//     req_valid/req_op/req_addr/req_wdata/req_rt_old : request from execute
//     busy          : LSU cannot accept a request this cycle
//     resp_valid    : one-cycle completion pulse (in DONE)
//     resp_rdata    : load result, 0 for stores and errors
//     addr_error    : misaligned access flag, valid with resp_valid
//     mem_*         : word-aligned memory port (1-cycle read latency)
//     dbg_state     : current FSM state, for observation only
//
//   Handshake: a request is taken on a posedge where req_valid=1, busy=0 and
//   clk_enable=1. busy is low only in IDLE and DONE, so a new request can be
//   taken in the same cycle that resp_valid pulses. resp_valid is a single
//   cycle pulse with no back-pressure.
// ---------------------------------------------------------------------------
module mips_cpu_lsu
    import mips_cpu_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_enable,
    input  logic              req_valid,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [DATA_W-1:0] req_rt_old,
    output logic              busy,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              addr_error,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    output lsu_state_t        dbg_state
);

    if (DATA_W != 32) begin : g_data_w_check
        $error("mips_cpu_lsu: DATA_W must be 32");
    end

    lsu_state_t        state_q, state_d;
    lsu_op_t           op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rt_old_q, rt_old_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] store_word;
    logic              mem_write_c;
    lsu_op_t           req_op_e;

    assign req_op_e = lsu_op_t'(req_op);

    mips_cpu_lsu_align u_align (
        .op         (op_q),
        .byte_off   (addr_q[1:0]),
        .mem_word   (mem_readdata),
        .rt_old     (rt_old_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // State and request registers. Reset takes priority over clk_enable.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_LB;
            addr_q   <= '0;
            wdata_q  <= '0;
            rt_old_q <= '0;
            err_q    <= 1'b0;
        end else if (clk_enable) begin
            state_q  <= state_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rt_old_q <= rt_old_d;
            err_q    <= err_d;
        end
    end

    // Next-state and request latch.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rt_old_d = rt_old_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (req_valid) begin
                    op_d     = req_op_e;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    rt_old_d = req_rt_old;
                    err_d    = misaligned(req_op_e, req_addr[1:0]);
                    if (misaligned(req_op_e, req_addr[1:0])) begin
                        state_d = ST_DONE;
                    end else if (is_load(req_op_e)) begin
                        state_d = ST_RD;
                    end else if (req_op_e == OP_SW) begin
                        state_d = ST_WR;
                    end else if (is_store(req_op_e)) begin
                        state_d = ST_RMW_RD;
                    end else begin
                        // Unassigned encoding: complete with no memory access.
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD:     state_d = ST_DONE;
            ST_WR:     state_d = ST_DONE;
            ST_RMW_RD: state_d = ST_RMW_WR;
            ST_RMW_WR: state_d = ST_DONE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from the registered state. Memory read data arrives
    // one cycle after mem_read, i.e. in DONE (loads) or RMW_WR (sub-word stores).
    always_comb begin
        busy          = is_busy_state(state_q);
        resp_valid    = 1'b0;
        resp_rdata    = '0;
        addr_error    = 1'b0;
        mem_address   = {addr_q[ADDR_W-1:2], 2'b00};
        mem_read      = 1'b0;
        mem_write_c   = 1'b0;
        mem_writedata = '0;

        case (state_q)
            ST_RD:     mem_read = 1'b1;
            ST_RMW_RD: mem_read = 1'b1;
            ST_WR: begin
                mem_write_c   = 1'b1;
                mem_writedata = wdata_q;
            end
            ST_RMW_WR: begin
                mem_write_c   = 1'b1;
                mem_writedata = store_word;
            end
            ST_DONE: begin
                resp_valid = 1'b1;
                addr_error = err_q;
                if (!err_q && is_load(op_q)) begin
                    resp_rdata = load_data;
                end
            end
            default: ;
        endcase
    end

    // Block the write on the very edge that reset is applied so an
    // abandoned store never reaches memory.
    assign mem_write = mem_write_c & reset;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mips_cpu_lsu.sv
module tb_mips_cpu_lsu;
    import mips_cpu_lsu_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_enable = 1'b1;
    logic        req_valid = 1'b0;
    logic [3:0]  req_op = 4'h0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [31:0] req_rt_old = '0;
    logic        busy;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        addr_error;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata = '0;
    lsu_state_t  dbg_state;

    always #5 clk = ~clk;

    mips_cpu_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .clk_enable    (clk_enable),
        .req_valid     (req_valid),
        .req_op        (req_op),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_rt_old    (req_rt_old),
        .busy          (busy),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .addr_error    (addr_error),
        .mem_address   (mem_address),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .dbg_state     (dbg_state)
    );

    // ---------------- data memory model ----------------
    // Word array, 1-cycle registered read, write commits at posedge,
    // gated by the same clk_enable as the LSU.
    logic [31:0] mem [0:255];

    always @(posedge clk) begin
        if (clk_enable) begin
            if (mem_read)  mem_readdata <= mem[mem_address[9:2]];
            if (mem_write) mem[mem_address[9:2]] <= mem_writedata;
        end
    end

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge; the following posedge is the accept edge.
    task automatic issue(input lsu_op_t op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rt_old);
        req_valid  = 1'b1;
        req_op     = op;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rt_old = rt_old;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Counts negedges after the accept edge until resp_valid, and the memory
    // strobes seen on the way. Returns at the negedge where resp_valid is high.
    task automatic wait_resp(input string tag, input int exp_lat, input logic exp_err,
                             output int n_rd, output int n_wr);
        int cyc;
        logic [31:0] exp_data;
        cyc  = 0;
        n_rd = 0;
        n_wr = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (mem_read)  n_rd++;
            if (mem_write) n_wr++;
        end while (!resp_valid && cyc < 20);
        check_eq({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
        check_eq({tag, "_latency"}, cyc, exp_lat);
        check_eq({tag, "_addr_error"}, 32'(addr_error), 32'(exp_err));
        exp_data = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        check_eq({tag, "_rdata"}, resp_rdata, exp_data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int rd_cnt, wr_cnt, cyc;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h40] = 32'h8899AABB;

        // ---- reset state ----
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy",       32'(busy), 32'd0);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_resp_rdata", resp_rdata, 32'd0);
        check_eq("rst_addr_error", 32'(addr_error), 32'd0);
        check_eq("rst_mem_read",   32'(mem_read), 32'd0);
        check_eq("rst_mem_write",  32'(mem_write), 32'd0);
        check_eq("rst_mem_addr",   mem_address, 32'd0);
        check_eq("rst_mem_wdata",  mem_writedata, 32'd0);
        check_eq("rst_state",      32'(dbg_state), 32'(ST_IDLE));
        reset = 1'b1;
        @(negedge clk);

        // ---- byte loads, second one back-to-back from DONE ----
        exp_q.push_back(32'h000000AA);
        issue(OP_LBU, 32'h101, 32'h0, 32'h0);
        wait_resp("lbu", 2, 1'b0, rd_cnt, wr_cnt);
        check_eq("lbu_reads", rd_cnt, 1);
        check_eq("lbu_writes", wr_cnt, 0);
        exp_q.push_back(32'hFFFFFF88);
        issue(OP_LB, 32'h103, 32'h0, 32'h0);
        wait_resp("lb", 2, 1'b0, rd_cnt, wr_cnt);

        // DONE with no request returns to IDLE
        @(negedge clk);
        check_eq("done_to_idle", 32'(dbg_state), 32'(ST_IDLE));
        check_eq("idle_resp_valid", 32'(resp_valid), 32'd0);

        // ---- LWL / LWR ----
        exp_q.push_back(32'hAABB3344);
        issue(OP_LWL, 32'h101, 32'h0, 32'h11223344);
        wait_resp("lwl", 2, 1'b0, rd_cnt, wr_cnt);
        exp_q.push_back(32'h118899AA);
        issue(OP_LWR, 32'h101, 32'h0, 32'h11223344);
        wait_resp("lwr", 2, 1'b0, rd_cnt, wr_cnt);

        // ---- misaligned accesses ----
        exp_q.push_back(32'h0);
        issue(OP_LH, 32'h101, 32'h0, 32'h0);
        wait_resp("lh_err", 1, 1'b1, rd_cnt, wr_cnt);
        check_eq("lh_err_reads", rd_cnt, 0);
        check_eq("lh_err_writes", wr_cnt, 0);
        exp_q.push_back(32'h0);
        issue(OP_SW, 32'h102, 32'hDEADBEEF, 32'h0);
        wait_resp("sw_err", 1, 1'b1, rd_cnt, wr_cnt);
        check_eq("sw_err_writes", wr_cnt, 0);
        @(negedge clk);

        // ---- LW with 3-cycle clock-enable freeze ----
        exp_q.push_back(32'h8899AABB);
        issue(OP_LW, 32'h100, 32'h0, 32'h0);
        @(negedge clk);
        cyc = 1;
        clk_enable = 1'b0;
        repeat (3) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("frz_busy", 32'(busy), 32'd1);
        check_eq("frz_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("frz_mem_read", 32'(mem_read), 32'd1);
        clk_enable = 1'b1;
        while (!resp_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("frz_latency", cyc, 5);
        check_eq("frz_rdata", resp_rdata, exp_q.pop_front());
        @(negedge clk);

        // ---- SB read-modify-write ----
        exp_q.push_back(32'h0);
        issue(OP_SB, 32'h102, 32'h12345677, 32'h0);
        wait_resp("sb", 3, 1'b0, rd_cnt, wr_cnt);
        check_eq("sb_reads", rd_cnt, 1);
        check_eq("sb_writes", wr_cnt, 1);
        check_eq("sb_mem_word", mem[8'h40], 32'h8877AABB);
        exp_q.push_back(32'h8877AABB);
        issue(OP_LW, 32'h100, 32'h0, 32'h0);
        wait_resp("lw_after_sb", 2, 1'b0, rd_cnt, wr_cnt);

        // ---- SH into upper half of word 0x104, then halfword loads ----
        exp_q.push_back(32'h0);
        issue(OP_SH, 32'h106, 32'h1234BEEF, 32'h0);
        wait_resp("sh", 3, 1'b0, rd_cnt, wr_cnt);
        check_eq("sh_mem_word", mem[8'h41], 32'hBEEF0000);
        exp_q.push_back(32'hFFFFBEEF);
        issue(OP_LH, 32'h106, 32'h0, 32'h0);
        wait_resp("lh", 2, 1'b0, rd_cnt, wr_cnt);
        exp_q.push_back(32'h0000BEEF);
        issue(OP_LHU, 32'h106, 32'h0, 32'h0);
        wait_resp("lhu", 2, 1'b0, rd_cnt, wr_cnt);

        // ---- SW then LW / LWL k=0 / LWR k=3 ----
        exp_q.push_back(32'h0);
        issue(OP_SW, 32'h108, 32'hCAFEF00D, 32'h0);
        wait_resp("sw", 2, 1'b0, rd_cnt, wr_cnt);
        check_eq("sw_writes", wr_cnt, 1);
        exp_q.push_back(32'hCAFEF00D);
        issue(OP_LW, 32'h108, 32'h0, 32'h0);
        wait_resp("lw_sw", 2, 1'b0, rd_cnt, wr_cnt);
        exp_q.push_back(32'h0D223344);
        issue(OP_LWL, 32'h108, 32'h0, 32'h11223344);
        wait_resp("lwl_k0", 2, 1'b0, rd_cnt, wr_cnt);
        exp_q.push_back(32'h112233CA);
        issue(OP_LWR, 32'h10B, 32'h0, 32'h11223344);
        wait_resp("lwr_k3", 2, 1'b0, rd_cnt, wr_cnt);
        @(negedge clk);

        // ---- reset during RMW_RD of SH ----
        issue(OP_SH, 32'h100, 32'h00005555, 32'h0);
        @(negedge clk);
        check_eq("rmw_state", 32'(dbg_state), 32'(ST_RMW_RD));
        check_eq("rmw_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rmw_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check_eq("rmw_rst_busy", 32'(busy), 32'd0);
        check_eq("rmw_rst_write", 32'(mem_write), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rmw_rst_mem", mem[8'h40], 32'h8877AABB);

        // ---- reset while WR drives mem_write: write is suppressed ----
        issue(OP_SW, 32'h100, 32'hDEADBEEF, 32'h0);
        @(negedge clk);
        check_eq("wr_strobe", 32'(mem_write), 32'd1);
        reset = 1'b0;
        #1;
        check_eq("wr_rst_gated", 32'(mem_write), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        check_eq("wr_rst_mem", mem[8'h40], 32'h8877AABB);

        // ---- reset and req_valid together: request dropped ----
        reset = 1'b0;
        issue(OP_LW, 32'h100, 32'h0, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst_req_state", 32'(dbg_state), 32'(ST_IDLE));
        check_eq("rst_req_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
